// File: rtl/key_exp_seq_if.sv
// -----------------------------------------------------------------------------
// key_exp_seq_if
//   Control/handshake bundle between the AES key-expansion word sequencer and
//   the block that drives it and consumes its per-word commands.
//
//   Parameters
//     IDX_W : width of the word index (i_out)
//     RC_W  : width of the Rcon round index (rcon_idx_out)
//
//   Signals (direction as seen by the sequencer, i.e. the slave modport)
//     start_in       in   start one expansion (sampled in IDLE only)
//     abort_in       in   synchronous abort of a run in progress
//     conf_in        in   key size: 00=AES-128, 01=AES-192, 10=AES-256
//     word_ready_in  in   consumer accepts the current word
//     word_valid_out out  current index and flags are valid
//     i_out          out  word index i
//     imodk_out      out  i mod Nk
//     rcon_idx_out   out  i / Nk
//     copy_out       out  copy key word directly
//     rot_sub_out    out  RotWord + SubWord + Rcon
//     sub_only_out   out  SubWord only (AES-256)
//     last_out       out  final word of the schedule
//     busy_out       out  run in progress
//     done_out       out  one-cycle completion pulse
//     cfg_err_out    out  one-cycle pulse on start with illegal conf
// -----------------------------------------------------------------------------
interface key_exp_seq_if #(
  parameter int IDX_W = 6,
  parameter int RC_W  = 4
);
  logic             start_in;
  logic             abort_in;
  logic [1:0]       conf_in;
  logic             word_ready_in;
  logic             word_valid_out;
  logic [IDX_W-1:0] i_out;
  logic [3:0]       imodk_out;
  logic [RC_W-1:0]  rcon_idx_out;
  logic             copy_out;
  logic             rot_sub_out;
  logic             sub_only_out;
  logic             last_out;
  logic             busy_out;
  logic             done_out;
  logic             cfg_err_out;

  // Controller / consumer side
  modport master (
    output start_in, abort_in, conf_in, word_ready_in,
    input  word_valid_out, i_out, imodk_out, rcon_idx_out,
           copy_out, rot_sub_out, sub_only_out, last_out,
           busy_out, done_out, cfg_err_out
  );

  // Sequencer side
  modport slave (
    input  start_in, abort_in, conf_in, word_ready_in,
    output word_valid_out, i_out, imodk_out, rcon_idx_out,
           copy_out, rot_sub_out, sub_only_out, last_out,
           busy_out, done_out, cfg_err_out
  );
endinterface

// File: rtl/key_exp_seq.sv
// -----------------------------------------------------------------------------
// key_exp_seq
//   AES-128/192/256 key-expansion word sequencer. Walks the word index i from
//   0 to NB*(Nr+1)-1 and, for every word, presents i, i mod Nk, i / Nk and the
//   operation flags the key-schedule datapath needs. Each word is held until
//   the consumer accepts it (valid/ready), so the same outputs can also drive
//   the round-key RAM write port directly.
//
//   Parameters
//     NB    : state columns in 32-bit words (4 for AES)
//     IDX_W : word index width, must hold NB*15-1
//     RC_W  : Rcon round index width
//
//   Ports
//     clk_in : clock, rising edge
//     rst_in : asynchronous active-high reset
//     bus    : key_exp_seq_if.slave, see interface header for signal list
//
//   Sequencing
//     IDLE -> (start, legal conf) -> COPY (i < Nk) -> EXPAND (i >= Nk)
//          -> DONE (one cycle) -> IDLE
//     An abort in COPY/EXPAND returns to IDLE without a done pulse.
// -----------------------------------------------------------------------------
module key_exp_seq #(
  parameter int NB    = 4,
  parameter int IDX_W = 6,
  parameter int RC_W  = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  key_exp_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_COPY   = 2'b01;
  localparam logic [1:0] S_EXPAND = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  localparam logic [1:0] CONF_ILLEGAL = 2'b11;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       r_conf;
  logic [IDX_W-1:0] r_i;
  logic [3:0]       r_imodk;
  logic [RC_W-1:0]  r_rcon;
  logic             r_cfg_err;

  // ---------------------------------------------------------------------------
  // Derived combinational values
  // ---------------------------------------------------------------------------
  logic [3:0]       w_nk;
  logic [IDX_W-1:0] w_total;
  logic [IDX_W-1:0] w_last_i;
  logic             w_valid;
  logic             w_xfer;
  logic             w_is_last;
  logic             w_wrap;
  logic             w_copy_end;
  logic             w_start_ok;
  logic             w_start_bad;

  // Key geometry comes only from the latched configuration, so conf_in may
  // change freely once a run has started. The illegal code is never latched;
  // the default arm only keeps the decode total.
  always_comb begin
    w_nk    = 4'd4;
    w_total = IDX_W'(NB * 11);
    case (r_conf)
      2'b01: begin
        w_nk    = 4'd6;
        w_total = IDX_W'(NB * 13);
      end
      2'b10: begin
        w_nk    = 4'd8;
        w_total = IDX_W'(NB * 15);
      end
      default: begin
        w_nk    = 4'd4;
        w_total = IDX_W'(NB * 11);
      end
    endcase
  end

  assign w_last_i    = w_total - IDX_W'(1);
  assign w_valid     = (r_state == S_COPY) || (r_state == S_EXPAND);
  assign w_xfer      = w_valid && bus.word_ready_in;
  assign w_is_last   = (r_i == w_last_i);
  assign w_wrap      = (r_imodk == (w_nk - 4'd1));
  // In COPY the index equals the position within the first Nk words, so the
  // final copy word is exactly the one where imodk wraps.
  assign w_copy_end  = (r_state == S_COPY) && w_wrap;
  assign w_start_ok  = bus.start_in && (bus.conf_in != CONF_ILLEGAL);
  assign w_start_bad = bus.start_in && (bus.conf_in == CONF_ILLEGAL);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_conf    <= 2'b00;
      r_i       <= '0;
      r_imodk   <= '0;
      r_rcon    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_conf  <= bus.conf_in;
            r_i     <= '0;
            r_imodk <= '0;
            r_rcon  <= '0;
            r_state <= S_COPY;
          end else if (w_start_bad) begin
            r_cfg_err <= 1'b1;
          end
        end

        S_COPY, S_EXPAND: begin
          // Abort wins over a transfer presented in the same cycle.
          if (bus.abort_in) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_imodk <= '0;
            r_rcon  <= '0;
          end else if (w_xfer) begin
            if (w_is_last) begin
              r_state <= S_DONE;
              r_i     <= '0;
              r_imodk <= '0;
              r_rcon  <= '0;
            end else begin
              r_i <= r_i + IDX_W'(1);
              if (w_wrap) begin
                r_imodk <= '0;
                r_rcon  <= r_rcon + RC_W'(1);
              end else begin
                r_imodk <= r_imodk + 4'd1;
              end
              if (w_copy_end) begin
                r_state <= S_EXPAND;
              end
            end
          end
        end

        // A start seen here is intentionally dropped; the controller must
        // re-issue it once IDLE is reached.
        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state, so they are stable across a
  // stall and fall to zero the instant reset is applied. Counters are cleared
  // whenever the sequencer leaves a run, so the raw index is already zero
  // whenever valid is low.
  // ---------------------------------------------------------------------------
  assign bus.word_valid_out = w_valid;
  assign bus.i_out          = r_i;
  assign bus.imodk_out      = r_imodk;
  assign bus.rcon_idx_out   = r_rcon;
  // COPY/EXPAND already imply valid, which also keeps copy mutually exclusive
  // with both expansion flags (e.g. i = 4 in AES-256 is a copy, not SubWord).
  assign bus.copy_out       = (r_state == S_COPY);
  assign bus.rot_sub_out    = (r_state == S_EXPAND) && (r_imodk == 4'd0);
  assign bus.sub_only_out   = (r_state == S_EXPAND) && (w_nk == 4'd8) && (r_imodk == 4'd4);
  assign bus.last_out       = w_valid && w_is_last;
  assign bus.busy_out       = w_valid;
  assign bus.done_out       = (r_state == S_DONE);
  assign bus.cfg_err_out    = r_cfg_err;

endmodule

// File: tb/tb_key_exp_seq.sv
// -----------------------------------------------------------------------------
// tb_key_exp_seq
//   Directed bench for key_exp_seq: a table of key-size runs with hand-derived
//   totals, plus hand-written stall, illegal-config, abort and async-reset
//   sequences. Per-word expectations come from AES arithmetic on the bench's
//   own word counter.
// -----------------------------------------------------------------------------
module tb_key_exp_seq;
  localparam int IDX_W = 6;
  localparam int RC_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_exp_seq_if #(.IDX_W(IDX_W), .RC_W(RC_W)) bus();

  key_exp_seq #(.NB(4), .IDX_W(IDX_W), .RC_W(RC_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] conf;
    int         nk;
    int         words;
    int         n_rot;
    int         n_sub;
    int         last_rc;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({bus.word_valid_out, bus.i_out, bus.imodk_out, bus.rcon_idx_out,
                 bus.copy_out, bus.rot_sub_out, bus.sub_only_out, bus.last_out,
                 bus.busy_out, bus.done_out, bus.cfg_err_out});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one expansion from IDLE. Inputs change and outputs are observed 1ns
  // after each rising edge. stall_at/abort_at/reset_at select corner cases
  // (-1 = off). hold_start keeps start_in high during the run.
  task automatic run_seq(input string tag, input logic [1:0] c, input int nk,
                         input int total, input int stall_at, input int stall_len,
                         input int abort_at, input int reset_at, input bit hold_start,
                         output int words, output int n_copy, output int n_rot,
                         output int n_sub, output int done_cyc, output int done_cnt,
                         output int last_rc);
    int  exp_i;
    int  stalled;
    bit  finished;
    words = 0; n_copy = 0; n_rot = 0; n_sub = 0;
    done_cyc = -1; done_cnt = 0; last_rc = -1;
    exp_i = 0; stalled = 0; finished = 0;

    bus.start_in      = 1'b1;
    bus.conf_in       = c;
    bus.word_ready_in = 1'b1;
    bus.abort_in      = 1'b0;
    tick();
    if (!hold_start) bus.start_in = 1'b0;
    // Latched configuration must govern the rest of the run.
    bus.conf_in = c ^ 2'b01;

    for (int cyc = 1; cyc < 300 && !finished; cyc++) begin
      if (bus.word_valid_out) begin
        chk($sformatf("%s i=%0d i_out", tag, exp_i), int'(bus.i_out), exp_i);
        chk($sformatf("%s i=%0d imodk", tag, exp_i), int'(bus.imodk_out), exp_i % nk);
        chk($sformatf("%s i=%0d rcon_idx", tag, exp_i), int'(bus.rcon_idx_out), exp_i / nk);
        chk($sformatf("%s i=%0d copy", tag, exp_i), int'(bus.copy_out), int'(exp_i < nk));
        chk($sformatf("%s i=%0d rot_sub", tag, exp_i), int'(bus.rot_sub_out),
            int'(exp_i >= nk && exp_i % nk == 0));
        chk($sformatf("%s i=%0d sub_only", tag, exp_i), int'(bus.sub_only_out),
            int'(nk == 8 && exp_i >= nk && exp_i % nk == 4));
        chk($sformatf("%s i=%0d last", tag, exp_i), int'(bus.last_out),
            int'(exp_i == total - 1));
        chk($sformatf("%s i=%0d busy/done", tag, exp_i),
            int'({bus.busy_out, bus.done_out, bus.cfg_err_out}), 4);

        if (exp_i == abort_at) begin
          bus.abort_in      = 1'b1;
          bus.start_in      = 1'b0;
          bus.word_ready_in = 1'b1;
          tick();
          bus.abort_in = 1'b0;
          chk($sformatf("%s abort idle", tag), out_vec(), 0);
          tick();
          chk($sformatf("%s abort no done", tag), out_vec(), 0);
          return;
        end

        if (exp_i == reset_at) begin
          #2 rst = 1'b1;
          #1 chk($sformatf("%s async reset", tag), out_vec(), 0);
          tick();
          chk($sformatf("%s held reset", tag), out_vec(), 0);
          #2 rst = 1'b0;
          tick();
          chk($sformatf("%s after reset", tag), out_vec(), 0);
          return;
        end

        if (exp_i == stall_at && stalled < stall_len) begin
          bus.word_ready_in = 1'b0;
          stalled++;
        end else begin
          bus.word_ready_in = 1'b1;
          words++;
          n_copy += int'(bus.copy_out);
          n_rot  += int'(bus.rot_sub_out);
          n_sub  += int'(bus.sub_only_out);
          if (bus.last_out) last_rc = int'(bus.rcon_idx_out);
          exp_i++;
        end
      end else if (bus.done_out) begin
        done_cnt++;
        done_cyc = cyc;
        // A start arriving in the DONE cycle must be dropped.
        bus.start_in = 1'b1;
        bus.conf_in  = 2'b00;
        tick();
        bus.start_in = 1'b0;
        chk($sformatf("%s single done", tag), out_vec(), 0);
        finished = 1;
      end else begin
        chk($sformatf("%s unexpected idle cyc=%0d", tag, cyc), out_vec(), -1);
        finished = 1;
      end
      if (!finished) tick();
    end
    if (!finished) chk($sformatf("%s timeout", tag), 0, 1);
  endtask

  int words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc;

  initial begin
    bus.start_in      = 1'b0;
    bus.abort_in      = 1'b0;
    bus.conf_in       = 2'b00;
    bus.word_ready_in = 1'b0;

    // Reset state
    #1 chk("reset outputs", out_vec(), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("first cycle after release", out_vec(), 0);

    // Key-size table: {conf, Nk, words, RotWord count, SubWord-only count, final rcon}
    vecs[0] = '{"aes128", 2'b00, 4, 44, 10, 0, 10};
    vecs[1] = '{"aes192", 2'b01, 6, 52, 8,  0, 8};
    vecs[2] = '{"aes256", 2'b10, 8, 60, 7,  6, 7};

    for (int v = 0; v < 3; v++) begin
      run_seq(vecs[v].name, vecs[v].conf, vecs[v].nk, vecs[v].words, -1, 0, -1, -1, 0,
              words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
      chk({vecs[v].name, " words"}, words, vecs[v].words);
      chk({vecs[v].name, " copies"}, n_copy, vecs[v].nk);
      chk({vecs[v].name, " rot_sub count"}, n_rot, vecs[v].n_rot);
      chk({vecs[v].name, " sub_only count"}, n_sub, vecs[v].n_sub);
      chk({vecs[v].name, " last rcon"}, last_rc, vecs[v].last_rc);
      chk({vecs[v].name, " done cycle"}, done_cyc, vecs[v].words + 1);
      chk({vecs[v].name, " done pulses"}, done_cnt, 1);
    end

    // AES-192 with a 3-cycle stall on word 17 (imodk 5, rcon 2 held)
    run_seq("stall192", 2'b01, 6, 52, 17, 3, -1, -1, 0,
            words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
    chk("stall192 words", words, 52);
    chk("stall192 done cycle", done_cyc, 56);
    chk("stall192 done pulses", done_cnt, 1);
    chk("stall192 last rcon", last_rc, 8);

    // Illegal configuration
    bus.start_in = 1'b1;
    bus.conf_in  = 2'b11;
    tick();
    bus.start_in = 1'b0;
    bus.conf_in  = 2'b00;
    chk("cfg_err pulse", out_vec(), 1);
    tick();
    chk("cfg_err cleared", out_vec(), 0);
    run_seq("after_cfg_err", 2'b00, 4, 44, -1, 0, -1, -1, 0,
            words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
    chk("after_cfg_err done cycle", done_cyc, 45);
    chk("after_cfg_err done pulses", done_cnt, 1);

    // Abort on word 20 with ready high and start held
    run_seq("abort", 2'b00, 4, 44, -1, 0, 20, -1, 1,
            words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
    chk("abort words", words, 20);
    chk("abort done pulses", done_cnt, 0);
    run_seq("after_abort", 2'b00, 4, 44, -1, 0, -1, -1, 0,
            words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
    chk("after_abort words", words, 44);
    chk("after_abort done cycle", done_cyc, 45);

    // Asynchronous reset on word 30
    run_seq("reset", 2'b00, 4, 44, -1, 0, -1, 30, 0,
            words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
    chk("reset words", words, 30);
    chk("reset done pulses", done_cnt, 0);
    run_seq("after_reset", 2'b00, 4, 44, -1, 0, -1, -1, 0,
            words, n_copy, n_rot, n_sub, done_cyc, done_cnt, last_rc);
    chk("after_reset words", words, 44);
    chk("after_reset done cycle", done_cyc, 45);
    chk("after_reset done pulses", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
